// File: rtl/tri_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// tri_pwm_ctrl
//
// Purpose:
//   Drives the phase input of an external combinational triangle-carrier LUT
//   from a phase accumulator, registers the returned carrier, compares it
//   against a double-buffered modulation reference and turns the result into
//   a complementary high-side / low-side gate pair with programmable dead
//   time between every hand-over.
//
// Ports:
//   CLK     in   1    system clock, all logic on the rising edge
//   RST     in   1    asynchronous active-high reset
//   EN      in   1    run enable; low forces the gates off and clears phase
//   FTW     in   PW   frequency tuning word (phase increment per cycle)
//   FTW_LD  in   1    one-cycle pulse, captures FTW into the shadow register
//   REF     in   10   signed modulation reference
//   REF_LD  in   1    one-cycle pulse, captures REF into the shadow register
//   DEAD    in   DTW  dead time in cycles, sampled when a dead time starts
//   THETA   out  8    phase to the LUT (top 8 bits of the accumulator)
//   TRI_IN  in   10   signed carrier returned by the LUT
//   PWM_H   out  1    high-side gate
//   PWM_L   out  1    low-side gate
//   SYNC    out  1    one-cycle pulse marking the start of a carrier period
// ---------------------------------------------------------------------------
module tri_pwm_ctrl #(
    parameter int PW  = 16,
    parameter int DTW = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [PW-1:0]       FTW,
    input  logic                FTW_LD,
    input  logic signed [9:0]   REF,
    input  logic                REF_LD,
    input  logic [DTW-1:0]      DEAD,
    output logic [7:0]          THETA,
    input  logic signed [9:0]   TRI_IN,
    output logic                PWM_H,
    output logic                PWM_L,
    output logic                SYNC
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_HI    = 3'd1,
        ST_DT_HL = 3'd2,
        ST_LO    = 3'd3,
        ST_DT_LH = 3'd4
    } state_t;

    localparam logic [DTW-1:0] C_DT_ONE = DTW'(1);

    // Phase path registers
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_ftw_shd;
    logic [PW-1:0]      r_ftw_act;
    logic signed [9:0]  r_ref_shd;
    logic signed [9:0]  r_ref_act;
    logic signed [9:0]  r_tri_q;
    logic               r_sync;

    // Gate path registers
    state_t             r_state;
    logic [DTW-1:0]     r_dt_cnt;
    logic               r_pwm_h;
    logic               r_pwm_l;

    // Combinational
    logic [PW:0]        w_sum;
    logic               w_wrap;
    logic               w_cmp;
    logic               w_dt_done;
    state_t             w_state_nxt;
    logic [DTW-1:0]     w_dt_nxt;

    // The extra top bit of the sum is the carry that marks a period start.
    assign w_sum  = {1'b0, r_acc} + {1'b0, r_ftw_act};
    assign w_wrap = EN & w_sum[PW];

    // Strict signed compare: equality keeps the low side on.
    assign w_cmp     = (r_ref_act > r_tri_q);
    assign w_dt_done = (r_dt_cnt <= C_DT_ONE);

    // -----------------------------------------------------------------------
    // Phase accumulator, shadow registers and carrier sample
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_acc     <= '0;
            r_ftw_shd <= '0;
            r_ftw_act <= '0;
            r_ref_shd <= '0;
            r_ref_act <= '0;
            r_tri_q   <= '0;
            r_sync    <= 1'b0;
        end else begin
            if (FTW_LD) begin
                r_ftw_shd <= FTW;
            end
            if (REF_LD) begin
                r_ref_shd <= REF;
            end
            // Active copies take the shadow value as it was before this
            // edge, so a load pulse coinciding with a wrap lands one period
            // later. While stopped the active copies track the shadows.
            if (w_wrap || !EN) begin
                r_ftw_act <= r_ftw_shd;
                r_ref_act <= r_ref_shd;
            end
            if (EN) begin
                r_acc <= w_sum[PW-1:0];
            end else begin
                r_acc <= '0;
            end
            r_sync  <= w_wrap;
            // One cycle of LUT latency: the carrier for THETA is held here.
            r_tri_q <= TRI_IN;
        end
    end

    // -----------------------------------------------------------------------
    // Dead-time state machine: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_OFF;
            r_dt_cnt <= '0;
            r_pwm_h  <= 1'b0;
            r_pwm_l  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dt_cnt <= w_dt_nxt;
            // Gates are decoded from the next state so they change on the
            // same edge as the state and can never both be high.
            r_pwm_h  <= (w_state_nxt == ST_HI);
            r_pwm_l  <= (w_state_nxt == ST_LO);
        end
    end

    // -----------------------------------------------------------------------
    // Dead-time state machine: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dt_nxt    = r_dt_cnt;
        if (!EN) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_DT_LH;
                    w_dt_nxt    = DEAD;
                end
                ST_HI: begin
                    if (!w_cmp) begin
                        w_state_nxt = ST_DT_HL;
                        w_dt_nxt    = DEAD;
                    end
                end
                ST_DT_HL: begin
                    // Always finishes into LO; a compare that flipped back
                    // during the dead time is picked up by LO afterwards.
                    if (w_dt_done) begin
                        w_state_nxt = ST_LO;
                    end else begin
                        w_dt_nxt = r_dt_cnt - C_DT_ONE;
                    end
                end
                ST_LO: begin
                    if (w_cmp) begin
                        w_state_nxt = ST_DT_LH;
                        w_dt_nxt    = DEAD;
                    end
                end
                ST_DT_LH: begin
                    // DEAD = 0 and DEAD = 1 both end after one dead cycle.
                    if (w_dt_done) begin
                        w_state_nxt = w_cmp ? ST_HI : ST_LO;
                    end else begin
                        w_dt_nxt = r_dt_cnt - C_DT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end
    end

    assign THETA = r_acc[PW-1 -: 8];
    assign SYNC  = r_sync;
    assign PWM_H = r_pwm_h;
    assign PWM_L = r_pwm_l;

endmodule

// File: tb/tb_tri_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tri_pwm_ctrl
//
// Purpose:
//   Self-checking bench for tri_pwm_ctrl. A triangle LUT is modelled
//   combinationally from THETA. A behavioural reference (integer phase,
//   shadow/active values, one-cycle carrier delay and a gate sequencer
//   described as "conducting side + remaining dead cycles") predicts THETA,
//   SYNC, PWM_H and PWM_L every cycle. Directed steps and random traffic
//   drive the block.
// ---------------------------------------------------------------------------
module tb_tri_pwm_ctrl;

    localparam int PW  = 16;
    localparam int DTW = 8;
    localparam int MOD = 1 << PW;

    logic               CLK = 1'b0;
    logic               RST;
    logic               EN;
    logic [PW-1:0]      FTW;
    logic               FTW_LD;
    logic signed [9:0]  REF;
    logic               REF_LD;
    logic [DTW-1:0]     DEAD;
    logic [7:0]         THETA;
    logic signed [9:0]  TRI_IN;
    logic               PWM_H;
    logic               PWM_L;
    logic               SYNC;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_acc, m_ftw_shd, m_ftw_act, m_ref_shd, m_ref_act, m_tri_q;
    int m_sync;
    int m_mode;       // 0 off, 1 drive H, 2 dead then L, 3 drive L, 4 dead then compare
    int m_left;       // dead cycles still to run
    int m_dead_len;   // length of the dead time most recently started
    int m_h, m_l;

    // Observed dead-time tracker
    int prev_side;
    int low_run;

    tri_pwm_ctrl #(.PW(PW), .DTW(DTW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .FTW    (FTW),
        .FTW_LD (FTW_LD),
        .REF    (REF),
        .REF_LD (REF_LD),
        .DEAD   (DEAD),
        .THETA  (THETA),
        .TRI_IN (TRI_IN),
        .PWM_H  (PWM_H),
        .PWM_L  (PWM_L),
        .SYNC   (SYNC)
    );

    always #5 CLK = ~CLK;

    // Triangle carrier: -512 at phase 0 rising to +504, then back to -512.
    function automatic logic signed [9:0] lut(input logic [7:0] t);
        int ti;
        int v;
        ti = int'(t);
        if (ti < 128) v = -512 + 8 * ti;
        else          v = 1528 - 8 * ti;
        return v[9:0];
    endfunction

    assign TRI_IN = lut(THETA);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_ftw_shd = 0; m_ftw_act = 0; m_ref_shd = 0; m_ref_act = 0;
        m_tri_q = 0; m_sync = 0; m_mode = 0; m_left = 0; m_dead_len = 1;
        m_h = 0; m_l = 0;
        prev_side = 0; low_run = 0;
    endtask

    function automatic bit model_wraps_now();
        return EN && (m_acc + m_ftw_act >= MOD);
    endfunction

    // Advance the reference by one clock edge using the pre-edge inputs.
    task automatic model_edge();
        int  sum, n_acc, n_tri;
        bit  wrap, cmp;
        int  dmax;
        if (RST) begin
            model_reset();
            return;
        end
        sum   = m_acc + m_ftw_act;
        wrap  = EN && (sum >= MOD);
        n_acc = EN ? (sum % MOD) : 0;
        n_tri = int'(lut(m_acc[PW-1 -: 8]));
        cmp   = (m_ref_act > m_tri_q);
        dmax  = (int'(DEAD) < 1) ? 1 : int'(DEAD);
        if (wrap || !EN) begin
            m_ftw_act = m_ftw_shd;
            m_ref_act = m_ref_shd;
        end
        if (FTW_LD) m_ftw_shd = int'(FTW);
        if (REF_LD) m_ref_shd = int'(REF);
        m_acc   = n_acc;
        m_sync  = wrap;
        m_tri_q = n_tri;
        if (!EN) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 4; m_left = dmax; m_dead_len = dmax; end
                1: if (!cmp) begin m_mode = 2; m_left = dmax; m_dead_len = dmax; end
                2: if (m_left <= 1) m_mode = 3; else m_left--;
                3: if (cmp) begin m_mode = 4; m_left = dmax; m_dead_len = dmax; end
                default: if (m_left <= 1) m_mode = cmp ? 1 : 3; else m_left--;
            endcase
        end
        m_h = (m_mode == 1);
        m_l = (m_mode == 3);
    endtask

    // One clock: edge, model update, then sample 1 time unit later.
    task automatic step();
        int side;
        @(posedge CLK);
        model_edge();
        #1;
        check("theta", THETA, (m_acc >> (PW - 8)) & 8'hFF);
        check("sync",  SYNC,  m_sync);
        check("pwm_h", PWM_H, m_h);
        check("pwm_l", PWM_L, m_l);
        check("no_overlap", PWM_H & PWM_L, 0);
        side = PWM_H ? 1 : (PWM_L ? 2 : 0);
        if (side != 0) begin
            if (prev_side != 0 && side != prev_side)
                check("dead_len", low_run, m_dead_len);
            prev_side = side;
            low_run   = 0;
        end else begin
            low_run++;
        end
        if (m_mode == 0) begin
            prev_side = 0;
            low_run   = 0;
        end
        FTW_LD = 1'b0;
        REF_LD = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit found;
        model_reset();
        RST = 1'b1; EN = 1'b0; FTW = 16'h0100; FTW_LD = 1'b0;
        REF = '0; REF_LD = 1'b0; DEAD = 8'd4;

        // Reset and idle
        run(3);
        RST = 1'b0;
        FTW_LD = 1'b1;
        run(20);
        check("idle_theta", THETA, 0);

        // Period, SYNC and dead time with REF = 0
        REF = 10'sd0; REF_LD = 1'b1;
        step();
        EN = 1'b1;
        run(700);

        // Mid-period reference change
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (THETA == 8'h80) found = 1;
        end
        check("wait_mid", found, 1);
        REF = 10'sd200; REF_LD = 1'b1;
        run(600);

        // Reference load on the exact wrap cycle
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (model_wraps_now()) found = 1;
            else step();
        end
        check("wait_wrap", found, 1);
        REF = -10'sd100; REF_LD = 1'b1;
        run(600);

        // Boundary references, loaded while stopped so they apply at once
        EN = 1'b0; REF = 10'sd511; REF_LD = 1'b1; DEAD = 8'd3;
        run(2);
        EN = 1'b1;
        run(10);
        for (int i = 0; i < 300; i++) begin
            step();
            check("hold_h", PWM_H, 1);
        end
        EN = 1'b0; REF = -10'sd512; REF_LD = 1'b1;
        run(2);
        EN = 1'b1;
        run(10);
        for (int i = 0; i < 300; i++) begin
            step();
            check("hold_l", PWM_L, 1);
        end

        // DEAD = 0 with REF = 0
        EN = 1'b0; REF = 10'sd0; REF_LD = 1'b1; DEAD = 8'd0;
        run(2);
        EN = 1'b1;
        run(600);

        // EN drop while high side conducts
        DEAD = 8'd4;
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (PWM_H) found = 1;
        end
        check("wait_hi", found, 1);
        EN = 1'b0;
        step();
        check("en_drop_h", PWM_H, 0);
        check("en_drop_theta", THETA, 0);
        run(3);

        // Asynchronous reset in the middle of the entry dead time
        DEAD = 8'd10; EN = 1'b1;
        run(3);
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_dt_h", PWM_H, 0);
        check("rst_dt_l", PWM_L, 0);
        check("rst_dt_theta", THETA, 0);
        check("rst_dt_sync", SYNC, 0);
        run(2);
        RST = 1'b0; EN = 1'b0; FTW = 16'h0100; FTW_LD = 1'b1; REF = 10'sd300; REF_LD = 1'b1;
        DEAD = 8'd2;
        step();
        EN = 1'b1;

        // Asynchronous reset while the high side conducts
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (PWM_H) found = 1;
        end
        check("wait_hi2", found, 1);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_hi_h", PWM_H, 0);
        check("rst_hi_theta", THETA, 0);
        run(2);
        RST = 1'b0;
        EN = 1'b0;
        step();

        // Randomised traffic
        EN = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 4))
                    0: FTW = 16'h0100;
                    1: FTW = 16'h0080;
                    2: FTW = 16'h0333;
                    3: FTW = 16'h0000;
                    default: FTW = 16'($urandom_range(0, 16'h0800));
                endcase
                FTW_LD = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) begin
                REF = 10'($urandom);
                REF_LD = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) DEAD = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) EN = 1'b0;
            else if (!EN && $urandom_range(0, 3) == 0) EN = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
